// File: rtl/seg_display_ctrl_pkg.sv
// Shared definitions for the seven-segment display controller.
//   state_t    : arbitration states (BG / MSG / ALERT)
//   SRC_*      : codes reported on the src output
//   SEG_BLANK  : all cathodes off (active-low)
//   AN_OFF     : all anodes off (active-low)
//   src_of()   : maps an arbitration state to its src code
package seg_display_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BG    = 2'd0,
    ST_MSG   = 2'd1,
    ST_ALERT = 2'd2
  } state_t;

  localparam logic [1:0] SRC_BG    = 2'd0;
  localparam logic [1:0] SRC_MSG   = 2'd1;
  localparam logic [1:0] SRC_ALERT = 2'd2;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  function automatic logic [1:0] src_of(input state_t s);
    case (s)
      ST_MSG:   return SRC_MSG;
      ST_ALERT: return SRC_ALERT;
      default:  return SRC_BG;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// Digit scanner for a 4-digit multiplexed seven-segment display.
//   clk, rst    : clock, synchronous active-high reset
//   frame       : 32-bit frame, byte [31:24] drives the leftmost digit (idx 3)
//   blank       : 1 = all anodes off next cycle; the scan keeps running
//   an          : anodes, active-low one-hot, an[3] = leftmost
//   seg         : cathodes, active-low {g,f,e,d,c,b,a,dp}
//   frame_tick  : high in the last cycle of the idx 0 slot, i.e. the cycle
//                 whose edge wraps the scan back to idx 3 (frame boundary)
// Each digit is held for SCAN_DIV cycles; the first cycle of every slot is
// dark so the previous digit's cathodes never ghost onto the next anode.
module seg_scan_mux
  import seg_display_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] frame,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic          slot_end;

  assign slot_end   = (scan_cnt == SCAN_LAST);
  assign frame_tick = slot_end && (idx == 2'd0);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its neighbours; blocking here would create order-
  // dependent simulation and mismatch the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      an       <= AN_OFF;
      seg      <= SEG_BLANK;
    end else begin
      if (slot_end) begin
        scan_cnt <= '0;
        idx      <= idx - 2'd1;   // 3->2->1->0->3, wraps naturally
      end else begin
        scan_cnt <= scan_cnt + CW'(1);
      end

      // slot_end is the edge that opens a new slot: that slot's first cycle
      // is dark (ghost blanking), the digit lights from the second cycle.
      if (blank || slot_end) begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= frame[{idx, 3'b000} +: 8];
      end
    end
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Seven-segment display owner: arbitrates background / message / alert
// frames, holds timed frames for HOLD_CYCLES, and scans the chosen frame
// onto the shared anode/cathode pins.
//   clk, rst              : clock, synchronous active-high reset
//   bg_seg                : background frame, used live
//   msg_seg,   msg_req    : message frame, captured on the request pulse
//   alert_seg, alert_req  : alert frame, captured on the request pulse
//   msg_ack,   alert_ack  : registered one-cycle acknowledge of each request
//   blank                 : force display dark (scan keeps running)
//   an, seg               : display pins, active-low
//   src                   : source currently on the display (0 bg,1 msg,2 alert)
// A message arriving during an alert waits in a single pending slot (newest
// wins) and is shown for a full hold once the alert expires. The displayed
// frame only changes at a scan frame boundary so digits never tear.
module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter int SCAN_DIV    = 100_000,
  parameter int HOLD_CYCLES = 200_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bg_seg,
  input  logic [31:0] msg_seg,
  input  logic        msg_req,
  output logic        msg_ack,
  input  logic [31:0] alert_seg,
  input  logic        alert_req,
  output logic        alert_ack,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic [1:0]  src
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t        state, state_nx;
  logic [31:0]   msg_buf, alert_buf, pend_buf, frame_buf, sel_frame;
  logic          pend_valid;
  logic [HW-1:0] hold_cnt;
  logic          hold_done;
  logic          frame_tick;

  // decoded actions for this cycle
  logic hold_clr, msg_cap, msg_promote, alert_cap, pend_wr, pend_clr;

  assign hold_done = (hold_cnt == HOLD_LAST);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    hold_clr    = 1'b0;
    msg_cap     = 1'b0;
    msg_promote = 1'b0;
    alert_cap   = 1'b0;
    pend_wr     = 1'b0;
    pend_clr    = 1'b0;
    unique case (state)
      ST_BG, ST_MSG: begin
        if (alert_req) begin
          // alert wins; any current message is dropped, a simultaneous
          // message request waits behind the alert
          state_nx  = ST_ALERT;
          alert_cap = 1'b1;
          hold_clr  = 1'b1;
          pend_wr   = msg_req;
        end else if (msg_req) begin
          state_nx = ST_MSG;
          msg_cap  = 1'b1;
          hold_clr = 1'b1;
        end else if (state == ST_MSG && hold_done) begin
          state_nx = ST_BG;
          hold_clr = 1'b1;
        end
      end
      ST_ALERT: begin
        if (alert_req) begin
          alert_cap = 1'b1;
          hold_clr  = 1'b1;
          pend_wr   = msg_req;
        end else if (hold_done) begin
          hold_clr = 1'b1;
          pend_clr = 1'b1;
          if (msg_req) begin
            // a request landing on the expiry edge is newer than the slot
            state_nx = ST_MSG;
            msg_cap  = 1'b1;
          end else if (pend_valid) begin
            state_nx    = ST_MSG;
            msg_promote = 1'b1;
          end else begin
            state_nx = ST_BG;
          end
        end else begin
          pend_wr = msg_req;
        end
      end
      default: state_nx = ST_BG;
    endcase
  end

  always_comb begin
    sel_frame = bg_seg;
    unique case (state)
      ST_MSG:   sel_frame = msg_buf;
      ST_ALERT: sel_frame = alert_buf;
      default:  sel_frame = bg_seg;
    endcase
  end

  // NOTE: the frame/capture buffers are a handful of flops, not a RAM, so
  // they are reset: a mid-operation reset must not leave an old frame able
  // to reappear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BG;
      hold_cnt   <= '0;
      msg_buf    <= 32'hFFFF_FFFF;
      alert_buf  <= 32'hFFFF_FFFF;
      pend_buf   <= 32'hFFFF_FFFF;
      pend_valid <= 1'b0;
      frame_buf  <= 32'hFFFF_FFFF;
      src        <= SRC_BG;
      msg_ack    <= 1'b0;
      alert_ack  <= 1'b0;
    end else begin
      state     <= state_nx;
      msg_ack   <= msg_req;
      alert_ack <= alert_req;

      if (hold_clr)
        hold_cnt <= '0;
      else if (state != ST_BG && !hold_done)
        hold_cnt <= hold_cnt + HW'(1);

      if (msg_cap)          msg_buf <= msg_seg;
      else if (msg_promote) msg_buf <= pend_buf;

      if (alert_cap) alert_buf <= alert_seg;

      if (pend_wr) begin
        pend_valid <= 1'b1;
        pend_buf   <= msg_seg;
      end else if (pend_clr) begin
        pend_valid <= 1'b0;
      end

      if (frame_tick) begin
        frame_buf <= sel_frame;
        src       <= src_of(state);
      end
    end
  end

  seg_scan_mux #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .frame      (frame_buf),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl (SCAN_DIV=4, HOLD_CYCLES=20).
// Stimulus pushes cycle-stamped expectations; a negedge monitor pops and
// compares them against the pins when the run reaches that cycle.
// Cycle k = state after the k-th rising edge. With reset released before
// edge r, frame boundary m is edge r+3+16*m; digit 3 lights at f+1,
// digit 2 at f+5, digit 1 at f+9, digit 0 at f+13.
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bg_seg, msg_seg, alert_seg;
  logic        msg_req, alert_req, blank;
  logic        msg_ack, alert_ack;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [1:0]  src;

  always #5 clk = ~clk;

  seg_display_ctrl #(
    .SCAN_DIV    (4),
    .HOLD_CYCLES (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bg_seg    (bg_seg),
    .msg_seg   (msg_seg),
    .msg_req   (msg_req),
    .msg_ack   (msg_ack),
    .alert_seg (alert_seg),
    .alert_req (alert_req),
    .alert_ack (alert_ack),
    .blank     (blank),
    .an        (an),
    .seg       (seg),
    .src       (src)
  );

  typedef struct {
    int         cyc;
    int         tid;
    bit         do_disp;
    logic [3:0] an;
    logic [7:0] seg;
    logic [1:0] src;
    bit         do_ack;
    logic       ma;
    logic       aa;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   r_base = 4;
  int   tid = 0;

  localparam logic [31:0] BG  = 32'h81F3_4961;
  localparam logic [31:0] M1  = 32'h0101_0101;
  localparam logic [31:0] MA  = 32'h1234_5678;
  localparam logic [31:0] MB  = 32'h9ABC_DEF0;
  localparam logic [31:0] AC  = 32'hC0A4_B099;
  localparam logic [31:0] AD  = 32'h8892_F8C6;
  localparam logic [31:0] ME  = 32'h4F24_3012;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input exp_t e);
    int i = 0;
    while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
    sb.insert(i, e);
  endtask

  task automatic exp_disp(input int c, input logic [3:0] a, input logic [7:0] s,
                          input logic [1:0] sr);
    exp_t e;
    e = '{cyc: c, tid: tid, do_disp: 1'b1, an: a, seg: s, src: sr,
          do_ack: 1'b0, ma: 1'b0, aa: 1'b0};
    push(e);
  endtask

  task automatic exp_ack(input int c, input logic m, input logic a);
    exp_t e;
    e = '{cyc: c, tid: tid, do_disp: 1'b0, an: 4'h0, seg: 8'h00, src: 2'd0,
          do_ack: 1'b1, ma: m, aa: a};
    push(e);
  endtask

  // one full displayed frame: dark boundary cycle, then the 4 digits
  task automatic exp_frame(input int m, input logic [31:0] fr, input logic [1:0] s);
    int f;
    f = r_base + 3 + 16 * m;
    exp_disp(f,      4'b1111, 8'hFF,      s);
    exp_disp(f + 1,  4'b0111, fr[31:24],  s);
    exp_disp(f + 5,  4'b1011, fr[23:16],  s);
    exp_disp(f + 9,  4'b1101, fr[15:8],   s);
    exp_disp(f + 13, 4'b1110, fr[7:0],    s);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor: compare every expectation due at this cycle
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL t%0d missed: due cyc %0d got cyc %0d", e.tid, e.cyc, cyc);
      end else begin
        if (e.do_disp) begin
          check($sformatf("t%0d an", e.tid),  {28'd0, an},  {28'd0, e.an});
          check($sformatf("t%0d seg", e.tid), {24'd0, seg}, {24'd0, e.seg});
          check($sformatf("t%0d src", e.tid), {30'd0, src}, {30'd0, e.src});
        end
        if (e.do_ack) begin
          check($sformatf("t%0d msg_ack", e.tid),   {31'd0, msg_ack},   {31'd0, e.ma});
          check($sformatf("t%0d alert_ack", e.tid), {31'd0, alert_ack}, {31'd0, e.aa});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; msg_req = 1'b0; alert_req = 1'b0; blank = 1'b0;
    bg_seg = BG; msg_seg = '0; alert_seg = '0;

    // reset: dark display, bg source, no acks
    tid = 0;
    for (int c = 1; c <= 3; c++) begin
      exp_disp(c, 4'b1111, 8'hFF, 2'd0);
      exp_ack(c, 1'b0, 1'b0);
    end
    // first post-reset cycle lights idx 0 with the reset (blank) frame
    exp_disp(4, 4'b1110, 8'hFF, 2'd0);

    // 1: background frame after the first boundary (edge 7)
    tid = 1;
    exp_frame(0, BG, 2'd0);
    exp_disp(10, 4'b0111, 8'h81, 2'd0);
    exp_disp(11, 4'b1111, 8'hFF, 2'd0);
    wait_cyc(3);
    rst = 1'b0;

    // 2: message at edge 35 -> shown at boundaries 39 and 55 (hold expires
    //    on edge 55), background again at 71
    tid = 2;
    exp_frame(1, BG, 2'd0);
    exp_ack(35, 1'b1, 1'b0);
    exp_ack(36, 1'b0, 1'b0);
    exp_frame(2, M1, 2'd1);
    exp_frame(3, M1, 2'd1);
    exp_frame(4, BG, 2'd0);
    wait_cyc(34); msg_seg = M1; msg_req = 1'b1;
    wait_cyc(35); msg_req = 1'b0;

    // 3: message A at 95, alert+message B at 99 -> alert at 103,119,
    //    pending B at 135, background at 151; A never displayed
    tid = 3;
    exp_frame(5, BG, 2'd0);
    exp_ack(95, 1'b1, 1'b0);
    exp_ack(96, 1'b0, 1'b0);
    exp_ack(99, 1'b1, 1'b1);
    exp_ack(100, 1'b0, 1'b0);
    exp_frame(6, AC, 2'd2);
    exp_frame(7, AC, 2'd2);
    exp_frame(8, MB, 2'd1);
    exp_frame(9, BG, 2'd0);
    wait_cyc(94); msg_seg = MA; msg_req = 1'b1;
    wait_cyc(95); msg_req = 1'b0;
    wait_cyc(98); msg_seg = MB; msg_req = 1'b1; alert_seg = AC; alert_req = 1'b1;
    wait_cyc(99); msg_req = 1'b0; alert_req = 1'b0;

    // 4: message at 160, re-request at hold count 18 (edge 179) ->
    //    new frame at 183, held through boundary 199, background at 215
    tid = 4;
    exp_ack(160, 1'b1, 1'b0);
    exp_ack(179, 1'b1, 1'b0);
    exp_ack(180, 1'b0, 1'b0);
    exp_frame(10, MA, 2'd1);
    exp_frame(11, MB, 2'd1);
    exp_frame(12, MB, 2'd1);
    exp_frame(13, BG, 2'd0);
    wait_cyc(159); msg_seg = MA; msg_req = 1'b1;
    wait_cyc(160); msg_req = 1'b0;
    wait_cyc(178); msg_seg = MB; msg_req = 1'b1;
    wait_cyc(179); msg_req = 1'b0;

    // 5: blank sampled on edges 237..241 inside frame 14 (boundary 231)
    tid = 5;
    exp_disp(231, 4'b1111, 8'hFF, 2'd0);
    exp_disp(232, 4'b0111, 8'h81, 2'd0);
    exp_disp(236, 4'b1011, 8'hF3, 2'd0);
    exp_disp(237, 4'b1111, 8'hFF, 2'd0);
    exp_disp(240, 4'b1111, 8'hFF, 2'd0);
    exp_disp(242, 4'b1101, 8'h49, 2'd0);
    exp_disp(243, 4'b1111, 8'hFF, 2'd0);
    exp_disp(244, 4'b1110, 8'h61, 2'd0);
    exp_frame(15, BG, 2'd0);
    wait_cyc(236); blank = 1'b1;
    wait_cyc(241); blank = 1'b0;

    // 6: alert at 260 (shown from 263), message pending at 262, reset
    //    sampled on edges 265..267; afterwards pending never appears
    tid = 6;
    exp_ack(260, 1'b0, 1'b1);
    exp_ack(261, 1'b0, 1'b0);
    exp_ack(262, 1'b1, 1'b0);
    exp_disp(263, 4'b1111, 8'hFF, 2'd2);
    exp_disp(264, 4'b0111, AD[31:24], 2'd2);
    for (int c = 265; c <= 267; c++) begin
      exp_disp(c, 4'b1111, 8'hFF, 2'd0);
      exp_ack(c, 1'b0, 1'b0);
    end
    exp_disp(268, 4'b1110, 8'hFF, 2'd0);
    r_base = 268;
    exp_frame(0, BG, 2'd0);
    exp_frame(1, BG, 2'd0);
    exp_ack(299, 1'b0, 1'b1);
    exp_ack(300, 1'b0, 1'b0);
    exp_frame(2, AD, 2'd2);
    exp_frame(3, AD, 2'd2);
    exp_frame(4, BG, 2'd0);
    wait_cyc(259); alert_seg = AD; alert_req = 1'b1;
    wait_cyc(260); alert_req = 1'b0;
    wait_cyc(261); msg_seg = ME; msg_req = 1'b1;
    wait_cyc(262); msg_req = 1'b0;
    wait_cyc(264); rst = 1'b1; msg_req = 1'b1;
    wait_cyc(265); msg_req = 1'b0;
    wait_cyc(267); rst = 1'b0;
    wait_cyc(298); alert_req = 1'b1;
    wait_cyc(299); alert_req = 1'b0;

    wait_cyc(352);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
